// File: rtl/bit_reverse_pkg.sv
// bit_reverse_pkg: shared types and constants for the bit_reverse block.
// Holds the 2-bit permutation mode enum and the byte width.
package bit_reverse_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    BIT_REV      = 2'd0,
    BYTE_BIT_REV = 2'd1,
    BYTE_SWAP    = 2'd2,
    PASS         = 2'd3
  } mode_e;

endpackage

// File: rtl/bit_reverse_core.sv
// bit_reverse_core: purely combinational bit/byte permutation network.
// Ports: mode (permutation select), data (input word), result (permuted word).
module bit_reverse_core
  import bit_reverse_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  mode_e            mode,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] result
);

  localparam int NB = WIDTH / BYTE_W;

  logic [WIDTH-1:0] bit_rev;
  logic [WIDTH-1:0] byte_bit_rev;
  logic [WIDTH-1:0] byte_swap;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bit_rev[i] = data[WIDTH-1-i];
  end

  for (genvar b = 0; b < NB; b++) begin : g_byte
    for (genvar j = 0; j < BYTE_W; j++) begin : g_lane
      assign byte_bit_rev[b*BYTE_W+j] =
        data[b*BYTE_W+BYTE_W-1-j];
    end
    assign byte_swap[b*BYTE_W +: BYTE_W] =
      data[(NB-1-b)*BYTE_W +: BYTE_W];
  end

  always_comb begin
    result = data;
    unique case (mode)
      BIT_REV:      result = bit_rev;
      BYTE_BIT_REV: result = byte_bit_rev;
      BYTE_SWAP:    result = byte_swap;
      PASS:         result = data;
    endcase
  end

endmodule

// File: rtl/bit_reverse.sv
// bit_reverse: registered bit/byte permuter, one-cycle latency, no backpressure.
// Ports: clk, rst_n (async low), in_valid, mode[1:0], in_vector,
// out_valid, out_vector, out_parity (only with BIT_REVERSE_PARITY_EN).
module bit_reverse
  import bit_reverse_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] in_vector,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_vector
`ifdef BIT_REVERSE_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  if (WIDTH < BYTE_W || (WIDTH % BYTE_W) != 0) begin : g_width_chk
    $error("bit_reverse: WIDTH must be a multiple of 8 and >= 8");
  end

  logic [WIDTH-1:0] perm;
  logic [WIDTH-1:0] out_vector_d;
  logic [WIDTH-1:0] out_vector_q;
  logic             out_valid_q;

  bit_reverse_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .mode   (mode_e'(mode)),
    .data   (in_vector),
    .result (perm)
  );

  // Idle cycles keep the last result visible.
  always_comb begin
    out_vector_d = out_vector_q;
    if (in_valid) out_vector_d = perm;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vector_q <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      out_vector_q <= out_vector_d;
      out_valid_q  <= in_valid;
    end
  end

  assign out_vector = out_vector_q;
  assign out_valid  = out_valid_q;

`ifdef BIT_REVERSE_PARITY_EN
  // Parity taken from the next-state word so it always
  // matches the registered vector.
  logic parity_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_q <= 1'b0;
    else        parity_q <= ^out_vector_d;
  end

  assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_bit_reverse.sv
// tb_bit_reverse: scoreboard bench for bit_reverse at WIDTH 8 and 32.
// Define BIT_REVERSE_PARITY_EN to also check out_parity.
module tb_bit_reverse;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        v8 = 1'b0;
  logic [1:0]  m8 = 2'd0;
  logic [7:0]  d8 = '0;
  logic        ov8;
  logic [7:0]  od8;

  logic        v32 = 1'b0;
  logic [1:0]  m32 = 2'd0;
  logic [31:0] d32 = '0;
  logic        ov32;
  logic [31:0] od32;

`ifdef BIT_REVERSE_PARITY_EN
  logic        op8;
  logic        op32;
`endif

  int tests = 0;
  int fails = 0;

  logic [7:0]  q8[$];
  logic [31:0] q32[$];

  always #5 clk = ~clk;

  bit_reverse #(.WIDTH(8)) dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (v8),
    .mode       (m8),
    .in_vector  (d8),
    .out_valid  (ov8),
    .out_vector (od8)
`ifdef BIT_REVERSE_PARITY_EN
    ,
    .out_parity (op8)
`endif
  );

  bit_reverse #(.WIDTH(32)) dut32 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (v32),
    .mode       (m32),
    .in_vector  (d32),
    .out_valid  (ov32),
    .out_vector (od32)
`ifdef BIT_REVERSE_PARITY_EN
    ,
    .out_parity (op32)
`endif
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitors: pop one expectation per presented result.
  always @(negedge clk) begin
    if (rst_n && ov8) begin
      if (q8.size() == 0) begin
        chk("w8 unexpected out_valid", 32'd1, 32'd0);
      end else begin
        logic [7:0] e;
        e = q8.pop_front();
        chk("w8 out_vector", {24'd0, od8}, {24'd0, e});
`ifdef BIT_REVERSE_PARITY_EN
        chk("w8 out_parity", {31'd0, op8}, {31'd0, ^e});
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov32) begin
      if (q32.size() == 0) begin
        chk("w32 unexpected out_valid", 32'd1, 32'd0);
      end else begin
        logic [31:0] e;
        e = q32.pop_front();
        chk("w32 out_vector", od32, e);
`ifdef BIT_REVERSE_PARITY_EN
        chk("w32 out_parity", {31'd0, op32}, {31'd0, ^e});
`endif
      end
    end
  end

  // Called at posedge+1; returns at the next posedge+1.
  task automatic beat8(input logic [7:0] d, input logic [1:0] m,
                       input logic [7:0] e);
    v8 = 1'b1; d8 = d; m8 = m;
    q8.push_back(e);
    @(posedge clk); #1;
    v8 = 1'b0;
  endtask

  task automatic beat32(input logic [31:0] d, input logic [1:0] m,
                        input logic [31:0] e);
    v32 = 1'b1; d32 = d; m32 = m;
    q32.push_back(e);
    @(posedge clk); #1;
    v32 = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " w8 vec"},   {24'd0, od8}, 32'd0);
    chk({tag, " w8 valid"}, {31'd0, ov8}, 32'd0);
    chk({tag, " w32 vec"},  od32, 32'd0);
    chk({tag, " w32 valid"}, {31'd0, ov32}, 32'd0);
`ifdef BIT_REVERSE_PARITY_EN
    chk({tag, " w8 par"},  {31'd0, op8}, 32'd0);
    chk({tag, " w32 par"}, {31'd0, op32}, 32'd0);
`endif
  endtask

  initial begin
    #1;
    chk_reset("reset");
    v8 = 1'b1; d8 = 8'hFF; v32 = 1'b1; d32 = '1;
    @(posedge clk); #1;
    chk_reset("reset clocked");
    v8 = 1'b0; v32 = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Five back-to-back mode 0 beats, first one right after reset.
    beat8(8'b00011010, 2'd0, 8'b01011000);
    beat8(8'b10101010, 2'd0, 8'b01010101);
    beat8(8'b11110000, 2'd0, 8'b00001111);
    beat8(8'b10000001, 2'd0, 8'b10000001);
    beat8(8'b00000001, 2'd0, 8'b10000000);

    // WIDTH 8: modes 0/1 agree, mode 2 equals pass.
    beat8(8'b00011010, 2'd1, 8'b01011000);
    beat8(8'b00011010, 2'd2, 8'b00011010);
    beat8(8'b00011010, 2'd3, 8'b00011010);

    // WIDTH 32: each beat carries its own mode.
    beat32(32'h12345678, 2'd0, 32'h1E6A2C48);
    beat32(32'h12345678, 2'd1, 32'h482C6A1E);
    beat32(32'h12345678, 2'd2, 32'h78563412);
    beat32(32'h12345678, 2'd3, 32'h12345678);
    beat32(32'h00000001, 2'd0, 32'h80000000);
    beat32(32'h000000FF, 2'd2, 32'hFF000000);
    beat32(32'h0000F001, 2'd1, 32'h00000F80);

    // One beat then three idle cycles: single pulse, held data.
    beat32(32'hA5C3_0F01, 2'd2, 32'h010F_C3A5);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("idle out_valid", {31'd0, ov32}, 32'd0);
      chk("idle hold", od32, 32'h010F_C3A5);
    end

    // Reset mid-cycle with beats in flight: they must vanish.
    v8 = 1'b1; d8 = 8'h3C; m8 = 2'd0;
    v32 = 1'b1; d32 = 32'hDEADBEEF; m32 = 2'd3;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk_reset("midreset");
    v8 = 1'b0; v32 = 1'b0;
    @(posedge clk); #1;
    chk_reset("midreset held");
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post reset w8 valid", {31'd0, ov8}, 32'd0);

    // First valid beat after reset is accepted immediately.
    beat8(8'b10000001, 2'd0, 8'b10000001);
    beat32(32'h80000000, 2'd0, 32'h00000001);

`ifdef BIT_REVERSE_PARITY_EN
    beat8(8'b00011010, 2'd0, 8'b01011000);
    chk("parity 01011000", {31'd0, op8}, 32'd1);
    beat8(8'b10000001, 2'd0, 8'b10000001);
    chk("parity 10000001", {31'd0, op8}, 32'd0);
`endif

    // Drain: bounded wait for the monitors to empty the queues.
    for (int k = 0; k < 20; k++) begin
      if (q8.size() == 0 && q32.size() == 0) break;
      @(posedge clk); #1;
    end
    @(negedge clk); #1;
    chk("w8 results outstanding", q8.size(), 32'd0);
    chk("w32 results outstanding", q32.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bit_reverse.md
BIT_REVERSE -- requirements
Module: bit_reverse

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits; SHALL be a multiple of 8 and >= 8, any other value SHALL cause an elaboration error.
REQ-002 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port in_valid  input  1  in_vector and mode are valid this cycle.
REQ-005 Port mode  input  2  permutation select, sampled with in_valid.
REQ-006 Port in_vector  input  WIDTH  data to permute.
REQ-007 Port out_valid  output  1  out_vector holds a new result this cycle.
REQ-008 Port out_vector  output  WIDTH  registered permuted data.
REQ-009 Port out_parity  output  1  XOR of out_vector; present only when BIT_REVERSE_PARITY_EN is defined.

Function
REQ-010 mode 0 (BIT_REV) SHALL produce out[i] = in[WIDTH-1-i] for all i.
REQ-011 mode 1 (BYTE_BIT_REV) SHALL reverse bit order within each byte, byte positions unchanged.
REQ-012 mode 2 (BYTE_SWAP) SHALL reverse byte order, bit order within each byte unchanged.
REQ-013 mode 3 (PASS) SHALL produce out = in unchanged.
REQ-014 When WIDTH = 8, modes 0 and 1 SHALL give identical results and mode 2 SHALL equal PASS.
REQ-015 Latency SHALL be exactly one clock: a beat accepted at edge N SHALL appear on out_vector with out_valid = 1 after edge N.
REQ-016 out_valid SHALL be the registered copy of in_valid; there SHALL be no backpressure and every valid beat SHALL be accepted.
REQ-017 When in_valid = 0, out_vector SHALL hold its previous value and out_valid SHALL be 0.
REQ-018 Back-to-back valid beats SHALL give back-to-back results, one per cycle, each using its own sampled mode.
REQ-019 The permutation SHALL be purely combinational wiring ahead of the output register, with no arithmetic.

Reset
REQ-020 While rst_n = 0, out_vector SHALL be all zeros, out_valid SHALL be 0, and out_parity (if present) SHALL be 0, regardless of clk.
REQ-021 Reset asserted mid-stream SHALL discard any in-flight beat.
REQ-022 The first valid beat after rst_n deassertion SHALL be accepted on the first rising edge at which in_valid = 1.

Configuration
REQ-023 With macro BIT_REVERSE_PARITY_EN defined, out_parity SHALL exist and SHALL be registered together with out_vector, so that it always equals the XOR-reduction of out_vector.
REQ-024 With BIT_REVERSE_PARITY_EN undefined, the out_parity port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-025 Package bit_reverse_pkg SHALL hold the 2-bit mode enum typedef (BIT_REV = 0, BYTE_BIT_REV = 1, BYTE_SWAP = 2, PASS = 3) and the constant BYTE_W = 8.
REQ-026 The combinational permutation SHALL live in one sub-module, bit_reverse_core, with parameter WIDTH, inputs mode and data, and output result; bit_reverse SHALL add the registers, valid tracking and parity.

Verification
REQ-027 WIDTH = 8, mode 0, five consecutive valid beats SHALL produce these results, each one cycle later:
- 00011010 -> 01011000
- 10101010 -> 01010101
- 11110000 -> 00001111
- 10000001 -> 10000001
- 00000001 -> 10000000
REQ-028 WIDTH = 32, in 0x12345678: mode 0 -> 0x1E6A2C48; mode 1 -> 0x482C6A1E; mode 2 -> 0x78563412; mode 3 -> 0x12345678.
REQ-029 Valid beat followed by three idle cycles -> out_valid pulses for exactly one cycle and out_vector holds its value during the idle cycles.
REQ-030 Drive rst_n low between clock edges while a beat is in flight -> out_vector = 0 and out_valid = 0 immediately, and the beat is never output.
REQ-031 With BIT_REVERSE_PARITY_EN defined, WIDTH = 8, mode 0, in 00011010 -> out_vector 01011000 with out_parity = 1; in 10000001 -> out_parity = 0.
